// File: rtl/pkt_verdict_ctrl.sv
// pkt_verdict_ctrl
//
// Frames packets from the input FIFO into the drop-capable packet buffer,
// holds each completed packet until the CPU gives a forward/drop verdict
// through a toggle handshake on cmd_word, and exports per-packet status.
//
// Optional build macro: PKT_VERDICT_TIMEOUT_EN
//   When defined, a HOLD timer applies the default verdict cmd_word[2] after
//   TIMEOUT_CYCLES cycles in HOLD and raises to_flag. Otherwise HOLD waits
//   for the CPU indefinitely and to_flag is tied low.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_data/in_ctrl   upstream word and ctrl (ctrl != 0: module header or last)
//   in_wr / in_rdy    upstream handshake, word accepted when both high
//   buf_nearly_full   buffer backpressure
//   buf_data/buf_ctrl registered copy of the accepted word
//   buf_wr            buffer write strobe, qualified by buf_first/buf_last
//   buf_commit        one-cycle pulse, release held packet
//   buf_drop          one-cycle pulse, discard held packet
//   cmd_word          [0] verdict toggle, [1] 1=forward, [2] timeout default
//   status            {drop_cnt, fwd_cnt, held_len, 0, to_flag, runt,
//                      oversize, 0, state}
//
// state | meaning
// IDLE  | waiting for a module-header word to start a packet
// HDR   | counting header words after the module-header word
// BODY  | passing payload until the last word
// HOLD  | packet complete in buffer, waiting for verdict

module pkt_verdict_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int HDR_WORDS      = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic                  buf_nearly_full,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic [CTRL_WIDTH-1:0] buf_ctrl,
    output logic                  buf_wr,
    output logic                  buf_first,
    output logic                  buf_last,
    output logic                  buf_commit,
    output logic                  buf_drop,
    input  logic [31:0]           cmd_word,
    output logic [31:0]           status
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_BODY = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;

    localparam logic [7:0] HDR_LAST = 8'(HDR_WORDS - 1);

    logic [2:0] state;
    logic [7:0] hdr_cnt;
    logic [7:0] held_len;
    logic [7:0] held_inc;
    logic [7:0] fwd_cnt;
    logic [7:0] drop_cnt;
    logic       runt;
    logic       oversize;
    logic       to_flag;
    logic       tog_q;
    logic       accept;
    logic       ctrl_nz;
    logic       start_pkt;
    logic       cpu_tog;
    logic       verdict;
    logic       verdict_fwd;
    logic       unused_cmd;

    assign in_rdy    = !reset && (state != ST_HOLD) && !buf_nearly_full;
    assign accept    = in_wr && in_rdy;
    assign ctrl_nz   = |in_ctrl;
    assign start_pkt = accept && ctrl_nz && (state == ST_IDLE);
    assign cpu_tog   = cmd_word[0] != tog_q;
    assign held_inc  = (held_len == 8'hFF) ? 8'hFF : held_len + 8'd1;
    assign unused_cmd = ^cmd_word[31:2];

`ifdef PKT_VERDICT_TIMEOUT_EN
    localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] hold_cnt;
    logic        timeout_hit;

    assign timeout_hit = (state == ST_HOLD) && (hold_cnt == 32'd0);
    assign verdict     = (state == ST_HOLD) && (cpu_tog || timeout_hit);
    // A CPU toggle in the timeout cycle takes priority over the default.
    assign verdict_fwd = cpu_tog ? cmd_word[1] : cmd_word[2];

    // Down-counter reloads every cycle outside HOLD, so it starts fresh
    // on each HOLD entry and hits terminal count in the TIMEOUT_CYCLES-th
    // HOLD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= 32'd0;
            to_flag  <= 1'b0;
        end else begin
            if (state != ST_HOLD)
                hold_cnt <= TO_LOAD;
            else if (hold_cnt != 32'd0)
                hold_cnt <= hold_cnt - 32'd1;

            if (start_pkt)
                to_flag <= 1'b0;
            else if (timeout_hit && !cpu_tog)
                to_flag <= 1'b1;
        end
    end
`else
    assign verdict     = (state == ST_HOLD) && cpu_tog;
    assign verdict_fwd = cmd_word[1];
    assign to_flag     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hdr_cnt    <= 8'd0;
            held_len   <= 8'd0;
            fwd_cnt    <= 8'd0;
            drop_cnt   <= 8'd0;
            runt       <= 1'b0;
            oversize   <= 1'b0;
            // Absorb the current toggle level so reset never looks like a verdict.
            tog_q      <= cmd_word[0];
            buf_data   <= '0;
            buf_ctrl   <= '0;
            buf_wr     <= 1'b0;
            buf_first  <= 1'b0;
            buf_last   <= 1'b0;
            buf_commit <= 1'b0;
            buf_drop   <= 1'b0;
        end else begin
            tog_q      <= cmd_word[0];
            buf_wr     <= accept;
            buf_first  <= start_pkt;
            buf_last   <= accept && ctrl_nz && (state == ST_HDR || state == ST_BODY);
            buf_commit <= verdict && verdict_fwd;
            buf_drop   <= verdict && !verdict_fwd;
            if (accept) begin
                buf_data <= in_data;
                buf_ctrl <= in_ctrl;
            end

            case (state)
                ST_IDLE: begin
                    // ctrl==0 words here are written without markers and ignored.
                    if (start_pkt) begin
                        state    <= ST_HDR;
                        hdr_cnt  <= 8'd0;
                        held_len <= 8'd1;
                        runt     <= 1'b0;
                        oversize <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        held_len <= held_inc;
                        if (held_inc == 8'hFF)
                            oversize <= 1'b1;
                        if (ctrl_nz) begin
                            runt  <= 1'b1;
                            state <= ST_HOLD;
                        end else begin
                            hdr_cnt <= hdr_cnt + 8'd1;
                            if (hdr_cnt == HDR_LAST)
                                state <= ST_BODY;
                        end
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        held_len <= held_inc;
                        if (held_inc == 8'hFF)
                            oversize <= 1'b1;
                        if (ctrl_nz)
                            state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (verdict) begin
                        state   <= ST_IDLE;
                        hdr_cnt <= 8'd0;
                        if (verdict_fwd)
                            fwd_cnt <= fwd_cnt + 8'd1;
                        else
                            drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign status = {drop_cnt, fwd_cnt, held_len, 1'b0, to_flag, runt,
                     oversize, 1'b0, state};

endmodule
